bin_maxpool_stage: RTL and testbench
====================================

// Module: bin_maxpool_stage
// PURPOSE
//  Downstream stage of the binary 3x3 conv engine. Reads conv result frames from the
//  feature SRAM and applies 2x2/stride-2 binary max-pool (an OR over each 2x2 window).
//  Writes pooled frames to the output SRAM. Uses the same run/busy control and the same
//  1-cycle-latency SRAM ports as the conv engine, so it chains directly after conv.
// PARAMETERS
//  ADDR_W   12  SRAM address width (read and write)
//  DATA_W   16  SRAM word width; one word = one feature row, bit i = column i
//  MAX_N    16  largest supported frame dimension
// PORTS
//  clk                     in   1       single clock; all state updates on posedge
//  reset_b                 in   1       asynchronous active-low reset
//  pool_run                in   1       start pulse, sampled only in IDLE
//  pool_busy               out  1       high while a run is in progress
//  pool_sram_read_address  out  ADDR_W  feature SRAM read address, registered
//  sram_pool_read_data     in   DATA_W  read data, valid 1 cycle after the address
//  pool_sram_write_address out  ADDR_W  output SRAM write address, registered
//  pool_sram_write_data    out  DATA_W  write data, registered
//  pool_sram_write_enable  out  1       write strobe, one word per asserted cycle
// BEHAVIOUR
//  Input format: frames are stored back-to-back from address 0.
//   - Each frame is a header word followed by N row words, with N = header[4:0]
//     clamped to MAX_N.
//   - A header equal to 16'h00FF terminates the stream.
//  Output format: frames are packed from write address 0.
//   - Each frame is a header {11'd0, M} followed by M pooled rows, with M = floor(N/2).
//   - The stream ends with one 16'h00FF word.
//  Pool arithmetic: out row k, bit j = in[2k][2j] | in[2k][2j+1] | in[2k+1][2j] | in[2k+1][2j+1].
//   - Bits j >= M are 0.
//   - For odd N, the last row and last column are dropped, but all N rows are still
//     skipped so that the next header is read at base + 1 + N.
//  States: IDLE -> HDR -> ROWA -> ROWB -> (ROWA | SKIP | HDR) ... -> TERM -> IDLE.
//   - IDLE: outputs are held.
//     - When pool_run=1, go to HDR, force the read and write addresses to 0, and set
//       pool_busy=1 on the next edge.
//     - pool_run has no effect in any other state.
//   - HDR: capture the header one cycle after its address is issued.
//     - 00FF -> TERM.
//     - M=0 -> write header 0; go to SKIP if N=1, otherwise go to HDR at base+1+N.
//     - Otherwise -> write header M and go to ROWA.
//   - ROWA / ROWB: capture rows 2k and 2k+1 on consecutive cycles; the read address
//     advances by 1 every cycle.
//     - The cycle after the ROWB capture, write the pooled word (write_enable=1 for
//       that cycle only) and advance the write address by 1.
//     - After M pairs: go to SKIP for odd N, otherwise go to HDR.
//   - SKIP: advance the read address past the unused last row.
//   - TERM: write 16'h00FF at the current write address. The next cycle pool_busy=0,
//     the state returns to IDLE, and the read and write addresses hold their values.
//  Throughput: one pooled row per 2 read cycles. At most one SRAM write per cycle.
//   - Reads are never issued past the terminator address.
//  Write data is zero-extended to DATA_W and is held when write_enable=0.
//  Reset values: pool_busy=0, write_enable=0, all addresses=0, write data=0, state=IDLE.
//   - Reset asserted mid-run aborts immediately.
//   - No write strobe is issued after reset deasserts until a new pool_run.
//  Address arithmetic wraps modulo 2^ADDR_W; no overflow flag.
// TESTING
//  1. Single 4x4 frame. Input: mem 0004,0001,0000,0008,0004,00FF.
//     Expect writes [0]=0002, [1]=0001, [2]=0002, [3]=00FF; busy drops after the last write.
//  2. Single 16x16 all-ones frame. Expect 0008 followed by 8 words of 00FF, then 00FF
//     at address 9. Check exactly 2 cycles between the pooled writes.
//  3. Odd frame N=5, rows 001F x5, then an N=2 frame with rows 0001,0002.
//     Expect 0002,0003,0003,0001,0001,00FF. The second header must be read at address 6.
//  4. Degenerate frames: N=1 and N=0 headers before 00FF.
//     Expect writes 0000,0000,00FF and correct skip addressing.
//  5. pool_run pulsed while busy: no restart, and the address sequence is identical
//     to a single run.
//  6. reset_b asserted mid-frame: all outputs go to 0 asynchronously. A new run then
//     produces the full correct output from address 0.

Source files
------------

// File: rtl/bin_maxpool_stage_if.sv
// Run/busy control plus SRAM read and write ports of the binary max-pool stage.
// master = the pool stage, slave = the controller / SRAM side.
interface bin_maxpool_stage_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              pool_run;
  logic              pool_busy;
  logic [ADDR_W-1:0] pool_sram_read_address;
  logic [DATA_W-1:0] sram_pool_read_data;
  logic [ADDR_W-1:0] pool_sram_write_address;
  logic [DATA_W-1:0] pool_sram_write_data;
  logic              pool_sram_write_enable;

  modport master (
    input  pool_run,
    input  sram_pool_read_data,
    output pool_busy,
    output pool_sram_read_address,
    output pool_sram_write_address,
    output pool_sram_write_data,
    output pool_sram_write_enable
  );

  modport slave (
    output pool_run,
    output sram_pool_read_data,
    input  pool_busy,
    input  pool_sram_read_address,
    input  pool_sram_write_address,
    input  pool_sram_write_data,
    input  pool_sram_write_enable
  );
endinterface

// File: rtl/bin_maxpool_stage.sv
// Binary 2x2/stride-2 max-pool stage: streams conv frames from the feature SRAM
// and writes pooled frames (header + rows) to the output SRAM.
//
// state  | meaning
// IDLE   | waiting for pool_run, outputs held
// HDR    | header address presented (hdr_wait=0), header captured (hdr_wait=1)
// ROWA   | first cycle after header: pipeline fill; then capture even row 2k
// ROWB   | capture odd row 2k+1, pooled word written next cycle
// SKIP   | move read address past the unused last row of an odd frame
// TERM   | 16'h00FF terminator being written, busy drops next cycle
module bin_maxpool_stage #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int MAX_N  = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  bin_maxpool_stage_if.master  bus
);
  // N comes from header[4:0], so dimension counters never need more than 5 bits.
  localparam int N_W = 5;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ROWA, S_ROWB, S_SKIP, S_TERM} state_t;

  state_t            state, state_nxt;
  logic              hdr_wait, hdr_wait_nxt;
  logic              row_fill, row_fill_nxt;
  logic              busy, busy_nxt;
  logic              we, we_nxt;
  logic [ADDR_W-1:0] raddr, raddr_nxt;
  logic [ADDR_W-1:0] waddr, waddr_nxt;
  logic [ADDR_W-1:0] next_base, next_base_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic [DATA_W-1:0] row_a, row_a_nxt;
  logic [N_W-1:0]    n_cur, n_nxt;
  logic [N_W-1:0]    m_cur, m_nxt;
  logic [N_W-1:0]    k_cur, k_nxt;

  logic [DATA_W-1:0] rdata;
  logic [N_W-1:0]    hdr_n;
  logic [N_W-1:0]    hdr_m;
  logic [N_W-1:0]    k_inc;
  logic [DATA_W-1:0] pooled;

  assign rdata = bus.sram_pool_read_data;
  assign hdr_n = (rdata[4:0] > N_W'(MAX_N)) ? N_W'(MAX_N) : rdata[4:0];
  assign hdr_m = hdr_n >> 1;
  assign k_inc = k_cur + N_W'(1);

  // OR over each 2x2 window of the held even row and the odd row arriving now.
  always_comb begin
    pooled = '0;
    for (int j = 0; j < DATA_W / 2; j++) begin
      if (j < int'(m_cur)) begin
        pooled[j] = row_a[2*j] | row_a[2*j+1] | rdata[2*j] | rdata[2*j+1];
      end
    end
  end

  // Next-state and next-output computation.
  always_comb begin
    state_nxt     = state;
    hdr_wait_nxt  = hdr_wait;
    row_fill_nxt  = row_fill;
    busy_nxt      = busy;
    we_nxt        = 1'b0;
    raddr_nxt     = raddr;
    // a write completes this cycle; the terminator write leaves the address on itself
    waddr_nxt     = (we && state != S_TERM) ? waddr + ADDR_W'(1) : waddr;
    next_base_nxt = next_base;
    wdata_nxt     = wdata;
    row_a_nxt     = row_a;
    n_nxt         = n_cur;
    m_nxt         = m_cur;
    k_nxt         = k_cur;

    case (state)
      S_IDLE: begin
        if (bus.pool_run) begin
          state_nxt    = S_HDR;
          hdr_wait_nxt = 1'b0;
          raddr_nxt    = '0;
          waddr_nxt    = '0;
          busy_nxt     = 1'b1;
        end
      end

      S_HDR: begin
        if (!hdr_wait) begin
          hdr_wait_nxt = 1'b1;
        end else begin
          hdr_wait_nxt = 1'b0;
          if (rdata == DATA_W'(16'h00FF)) begin
            we_nxt    = 1'b1;
            wdata_nxt = DATA_W'(16'h00FF);
            state_nxt = S_TERM;
          end else begin
            n_nxt         = hdr_n;
            m_nxt         = hdr_m;
            k_nxt         = '0;
            next_base_nxt = raddr + ADDR_W'(hdr_n) + ADDR_W'(1);
            we_nxt        = 1'b1;
            wdata_nxt     = {{(DATA_W-N_W){1'b0}}, hdr_m};
            if (hdr_m == '0) begin
              if (hdr_n == N_W'(1)) begin
                state_nxt = S_SKIP;
              end else begin
                raddr_nxt = raddr + ADDR_W'(1);
              end
            end else begin
              raddr_nxt    = raddr + ADDR_W'(1);
              row_fill_nxt = 1'b1;
              state_nxt    = S_ROWA;
            end
          end
        end
      end

      S_ROWA: begin
        raddr_nxt = raddr + ADDR_W'(1);
        if (row_fill) begin
          row_fill_nxt = 1'b0;
        end else begin
          row_a_nxt = rdata;
          state_nxt = S_ROWB;
        end
      end

      S_ROWB: begin
        we_nxt    = 1'b1;
        wdata_nxt = pooled;
        k_nxt     = k_inc;
        if (k_inc == m_cur) begin
          // even N: read address already sits on the next header
          state_nxt = n_cur[0] ? S_SKIP : S_HDR;
        end else begin
          raddr_nxt = raddr + ADDR_W'(1);
          state_nxt = S_ROWA;
        end
      end

      S_SKIP: begin
        raddr_nxt = next_base;
        state_nxt = S_HDR;
      end

      S_TERM: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= S_IDLE;
      hdr_wait  <= 1'b0;
      row_fill  <= 1'b0;
      busy      <= 1'b0;
      we        <= 1'b0;
      raddr     <= '0;
      waddr     <= '0;
      next_base <= '0;
      wdata     <= '0;
      row_a     <= '0;
      n_cur     <= '0;
      m_cur     <= '0;
      k_cur     <= '0;
    end else begin
      state     <= state_nxt;
      hdr_wait  <= hdr_wait_nxt;
      row_fill  <= row_fill_nxt;
      busy      <= busy_nxt;
      we        <= we_nxt;
      raddr     <= raddr_nxt;
      waddr     <= waddr_nxt;
      next_base <= next_base_nxt;
      wdata     <= wdata_nxt;
      row_a     <= row_a_nxt;
      n_cur     <= n_nxt;
      m_cur     <= m_nxt;
      k_cur     <= k_nxt;
    end
  end

  assign bus.pool_busy               = busy;
  assign bus.pool_sram_read_address  = raddr;
  assign bus.pool_sram_write_address = waddr;
  assign bus.pool_sram_write_data    = wdata;
  assign bus.pool_sram_write_enable  = we;
endmodule

// File: tb/tb_bin_maxpool_stage.sv
// Self-checking bench for bin_maxpool_stage: directed vector table, hand-written
// multi-cycle sequences and random streams checked against a frame-level model.
module tb_bin_maxpool_stage;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  bin_maxpool_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bin_maxpool_stage #(.ADDR_W(AW), .DATA_W(DW), .MAX_N(16)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  logic [15:0] mem [0:4095];
  always @(posedge clk) bus.sram_pool_read_data <= mem[bus.pool_sram_read_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int wr_cyc_q[$];
  bit read_seen [0:4095];
  int max_raddr;

  // Output SRAM write port and read-address monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.pool_sram_write_enable) begin
      wr_addr_q.push_back(bus.pool_sram_write_address);
      wr_data_q.push_back(bus.pool_sram_write_data);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.pool_busy) begin
      read_seen[bus.pool_sram_read_address] = 1'b1;
      if (int'(bus.pool_sram_read_address) > max_raddr)
        max_raddr = int'(bus.pool_sram_read_address);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic clear_capture();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    for (int i = 0; i < 4096; i++) read_seen[i] = 1'b0;
    max_raddr = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Frame-level reference: walk headers, OR 2x2 windows, emit header/rows/terminator.
  task automatic model_stream(output int term);
    int base, n, m;
    logic [15:0] h, w, ra, rb;
    exp_q.delete();
    base = 0;
    term = 0;
    for (int guard = 0; guard < 4096; guard++) begin
      h = mem[base];
      if (h == 16'h00FF) begin
        exp_q.push_back(16'h00FF);
        term = base;
        return;
      end
      n = int'(h[4:0]);
      if (n > 16) n = 16;
      m = n / 2;
      exp_q.push_back(16'(m));
      for (int k = 0; k < m; k++) begin
        ra = mem[base + 1 + 2*k];
        rb = mem[base + 2 + 2*k];
        w = 16'h0000;
        for (int j = 0; j < m; j++)
          w[j] = ra[2*j] | ra[2*j+1] | rb[2*j] | rb[2*j+1];
        exp_q.push_back(w);
      end
      base = base + 1 + n;
    end
  endtask

  // Pulse pool_run, wait for busy to fall (bounded), then compare captured writes.
  task automatic run_and_check(input string tag, input int term, input int repulse_at);
    int c;
    clear_capture();
    @(negedge clk) bus.pool_run = 1'b1;
    @(negedge clk) bus.pool_run = 1'b0;
    c = 0;
    while (bus.pool_busy && c < 2000) begin
      @(negedge clk);
      c++;
      if (c == repulse_at) bus.pool_run = 1'b1;
      else bus.pool_run = 1'b0;
    end
    bus.pool_run = 1'b0;
    check({tag, " busy_timeout"}, 32'(bus.pool_busy), 32'd0);
    repeat (4) @(negedge clk);
    check({tag, " busy_stays_low"}, 32'(bus.pool_busy), 32'd0);
    check({tag, " write_count"}, 32'(wr_data_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      check($sformatf("%s waddr[%0d]", tag, i), 32'(wr_addr_q[i]), 32'(i));
      check($sformatf("%s wdata[%0d]", tag, i), 32'(wr_data_q[i]), 32'(exp_q[i]));
    end
    check({tag, " read_past_term"}, 32'(max_raddr > term), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] in_w [0:11];
    int          in_len;
    logic [15:0] exp_w [0:7];
    int          exp_len;
    int          must_read;
  } vec_t;

  vec_t vecs [0:2];

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},  32'(bus.pool_busy), 32'd0);
    check({tag, " we"},    32'(bus.pool_sram_write_enable), 32'd0);
    check({tag, " raddr"}, 32'(bus.pool_sram_read_address), 32'd0);
    check({tag, " waddr"}, 32'(bus.pool_sram_write_address), 32'd0);
    check({tag, " wdata"}, 32'(bus.pool_sram_write_data), 32'd0);
  endtask

  initial begin
    int term, addr, nfr, nfield, ncl;
    logic [15:0] hdr;

    vecs[0].name = "four";
    vecs[0].in_w = '{16'h0004, 16'h0001, 16'h0000, 16'h0008, 16'h0004, 16'h00FF,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[0].in_len = 6;
    vecs[0].exp_w = '{16'h0002, 16'h0001, 16'h0002, 16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[0].exp_len = 4;
    vecs[0].must_read = 5;

    vecs[1].name = "odd5";
    vecs[1].in_w = '{16'h0005, 16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F,
                     16'h0002, 16'h0001, 16'h0002, 16'h00FF, 16'h0, 16'h0};
    vecs[1].in_len = 10;
    vecs[1].exp_w = '{16'h0002, 16'h0003, 16'h0003, 16'h0001, 16'h0001, 16'h00FF, 16'h0, 16'h0};
    vecs[1].exp_len = 6;
    vecs[1].must_read = 6;

    vecs[2].name = "degen";
    vecs[2].in_w = '{16'h0001, 16'hABCD, 16'h0000, 16'h00FF, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[2].in_len = 4;
    vecs[2].exp_w = '{16'h0000, 16'h0000, 16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[2].exp_len = 3;
    vecs[2].must_read = 2;

    bus.pool_run = 1'b0;
    reset_b = 1'b0;
    clear_mem();
    clear_capture();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vector table.
    for (int v = 0; v < 3; v++) begin
      clear_mem();
      for (int i = 0; i < vecs[v].in_len; i++) mem[i] = vecs[v].in_w[i];
      exp_q.delete();
      for (int i = 0; i < vecs[v].exp_len; i++) exp_q.push_back(vecs[v].exp_w[i]);
      run_and_check(vecs[v].name, vecs[v].in_len - 1, -1);
      check({vecs[v].name, " must_read"}, 32'(read_seen[vecs[v].must_read]), 32'd1);
    end

    // 16x16 all ones: pooled rows must come out exactly 2 cycles apart.
    clear_mem();
    mem[0] = 16'h0010;
    for (int i = 1; i <= 16; i++) mem[i] = 16'hFFFF;
    mem[17] = 16'h00FF;
    exp_q.delete();
    exp_q.push_back(16'h0008);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h00FF);
    run_and_check("full16", 17, -1);
    for (int i = 2; i <= 8 && i < wr_cyc_q.size(); i++)
      check($sformatf("full16 spacing[%0d]", i), 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd2);

    // pool_run pulsed mid-run must not restart the stream.
    clear_mem();
    for (int i = 0; i < vecs[1].in_len; i++) mem[i] = vecs[1].in_w[i];
    model_stream(term);
    run_and_check("rerun", term, 5);

    // Asynchronous reset mid-frame, then a clean full run.
    clear_mem();
    for (int i = 0; i < vecs[1].in_len; i++) mem[i] = vecs[1].in_w[i];
    clear_capture();
    @(negedge clk) bus.pool_run = 1'b1;
    @(negedge clk) bus.pool_run = 1'b0;
    repeat (7) @(negedge clk);
    check("midrun busy_before_reset", 32'(bus.pool_busy), 32'd1);
    #2 reset_b = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk) reset_b = 1'b1;
    clear_capture();
    repeat (5) @(negedge clk);
    check("post_reset no_write", 32'(wr_data_q.size()), 32'd0);
    check("post_reset busy", 32'(bus.pool_busy), 32'd0);
    model_stream(term);
    run_and_check("after_reset", term, -1);

    // Random streams against the frame-level model.
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      addr = 0;
      nfr = int'($urandom_range(1, 4));
      for (int f = 0; f < nfr; f++) begin
        nfield = int'($urandom_range(0, 31));
        hdr = 16'($urandom);
        hdr[4:0] = 5'(nfield);
        if (hdr == 16'h00FF) hdr[8] = 1'b1;
        mem[addr] = hdr;
        ncl = (nfield > 16) ? 16 : nfield;
        for (int r = 1; r <= ncl; r++) mem[addr + r] = 16'($urandom);
        addr = addr + 1 + ncl;
      end
      mem[addr] = 16'h00FF;
      model_stream(term);
      run_and_check($sformatf("rand%0d", t), term, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
